// File: rtl/load_store_unit_if.sv
// Memory-side handshake bundle between one thread's LSU and the memory controller.
// The LSU is the master: it raises valid with address/data, the controller answers with ready.
interface load_store_unit_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;
   logic                 mem_write_valid;
   logic [ADDR_BITS-1:0] mem_write_address;
   logic [DATA_BITS-1:0] mem_write_data;
   logic                 mem_write_ready;

   modport master (
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   modport slave (
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// Per-thread load/store unit. One LDR/STR transaction per instruction:
// IDLE -> REQUESTING -> WAITING (until ready) -> DONE (until core UPDATE) -> IDLE.
// The scheduler watches lsu_state and holds the core in WAIT until every thread reports DONE.
module load_store_unit #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [7:0]           rs,
   input  logic [DATA_BITS-1:0] rt,
   load_store_unit_if.master    mem,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out
);

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      REQUESTING = 2'b01,
      WAITING    = 2'b10,
      DONE       = 2'b11
   } lsu_state_t;

   lsu_state_t           state;
   logic                 is_read;   // latched direction; a read wins when both enables are set
   logic [ADDR_BITS-1:0] addr_q;
   logic [DATA_BITS-1:0] wdata_q;
   logic                 rvalid_q;
   logic                 wvalid_q;
   logic [ADDR_BITS-1:0] rs_fit;

   // rs is an 8-bit register value; fit it to the memory address width
   assign rs_fit = ADDR_BITS'(rs);

   assign mem.mem_read_valid    = rvalid_q;
   assign mem.mem_read_address  = addr_q;
   assign mem.mem_write_valid   = wvalid_q;
   assign mem.mem_write_address = addr_q;
   assign mem.mem_write_data    = wdata_q;
   assign lsu_state             = state;

   // Transaction FSM with registered valids, operands and load result; enable=0 freezes everything
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         is_read  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         lsu_out  <= '0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (core_state == CORE_REQUEST &&
                   (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                  addr_q  <= rs_fit;
                  wdata_q <= rt;
                  is_read <= decoded_mem_read_enable;
                  state   <= REQUESTING;
               end
            end
            REQUESTING: begin
               // only one direction is ever raised, so the valids are mutually exclusive
               if (is_read) rvalid_q <= 1'b1;
               else         wvalid_q <= 1'b1;
               state <= WAITING;
            end
            WAITING: begin
               // ready of the other direction is deliberately ignored
               if (is_read && rvalid_q && mem.mem_read_ready) begin
                  rvalid_q <= 1'b0;
                  lsu_out  <= mem.mem_read_data;
                  state    <= DONE;
               end else if (!is_read && wvalid_q && mem.mem_write_ready) begin
                  wvalid_q <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (core_state == CORE_UPDATE) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of LDR/STR transactions with memory
// stall counts, plus hand-written sequences for enable freeze and async reset.
module tb_load_store_unit;

   localparam logic [2:0] CS_IDLE    = 3'b000;
   localparam logic [2:0] CS_REQUEST = 3'b011;
   localparam logic [2:0] CS_WAIT    = 3'b100;
   localparam logic [2:0] CS_UPDATE  = 3'b110;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       rd_en, wr_en;
   logic [7:0] rs, rt;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;

   int tests = 0;
   int fails = 0;

   load_store_unit_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem_if ();

   load_store_unit #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .rs                       (rs),
      .rt                       (rt),
      .mem                      (mem_if),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] rs;
      logic [7:0] rt;
      logic [7:0] rdata;
      int         stall;     // cycles of low ready before the accepting cycle
      logic [2:0] cs_wait;   // core_state driven while the unit is busy
      logic       exp_rd;    // 1: read valid expected, 0: write valid expected
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one full transaction through the unit and check every cycle of it
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      core_state = CS_REQUEST; rd_en = v.rd; wr_en = v.wr; rs = v.rs; rt = v.rt;
      mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
      @(negedge clk);
      chk("req_state", lsu_state, 2'b01);
      chk("req_rvalid", mem_if.mem_read_valid, 1'b0);
      chk("req_wvalid", mem_if.mem_write_valid, 1'b0);
      // change the operands to prove the unit uses its latched copy
      core_state = v.cs_wait; rd_en = 1'b0; wr_en = 1'b0; rs = 8'hEE; rt = 8'hEE;
      @(negedge clk);
      for (int i = 0; i <= v.stall; i++) begin
         chk("wait_state", lsu_state, 2'b10);
         chk("wait_rvalid", mem_if.mem_read_valid, v.exp_rd);
         chk("wait_wvalid", mem_if.mem_write_valid, !v.exp_rd);
         if (v.exp_rd) chk("wait_raddr", mem_if.mem_read_address, v.rs);
         else begin
            chk("wait_waddr", mem_if.mem_write_address, v.rs);
            chk("wait_wdata", mem_if.mem_write_data, v.rt);
         end
         if (i < v.stall) begin
            // wrong-direction ready must be ignored
            mem_if.mem_read_ready  = !v.exp_rd;
            mem_if.mem_write_ready = v.exp_rd;
            mem_if.mem_read_data   = ~v.rdata;
         end else begin
            mem_if.mem_read_ready  = v.exp_rd;
            mem_if.mem_write_ready = !v.exp_rd;
            mem_if.mem_read_data   = v.rdata;
         end
         @(negedge clk);
      end
      mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
      chk("done_state", lsu_state, 2'b11);
      chk("done_rvalid", mem_if.mem_read_valid, 1'b0);
      chk("done_wvalid", mem_if.mem_write_valid, 1'b0);
      chk("done_out", lsu_out, v.exp_out);
      core_state = CS_WAIT;
      @(negedge clk);
      chk("done_hold", lsu_state, 2'b11);
      core_state = CS_UPDATE;
      @(negedge clk);
      chk("update_idle", lsu_state, 2'b00);
      chk("update_out", lsu_out, v.exp_out);
      core_state = CS_IDLE;
   endtask

   initial begin
      //          rd    wr    rs     rt     rdata  stall cs_wait    exp_rd exp_out
      vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 0, CS_WAIT,   1'b1, 8'hA5};
      vecs[1] = '{1'b0, 1'b1, 8'h20, 8'h55, 8'h00, 4, CS_WAIT,   1'b0, 8'hA5};
      vecs[2] = '{1'b1, 1'b1, 8'h30, 8'h77, 8'h3C, 1, CS_WAIT,   1'b1, 8'h3C};
      vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 2, CS_UPDATE, 1'b1, 8'h00};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 0, CS_UPDATE, 1'b0, 8'h00};

      reset = 1'b0; enable = 1'b1; core_state = CS_IDLE;
      rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
      mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0; mem_if.mem_read_data = 8'h00;
      #2;
      chk("rst_state", lsu_state, 2'b00);
      chk("rst_out", lsu_out, 8'h00);
      chk("rst_rvalid", mem_if.mem_read_valid, 1'b0);
      chk("rst_wvalid", mem_if.mem_write_valid, 1'b0);
      chk("rst_waddr", mem_if.mem_write_address, 8'h00);
      chk("rst_wdata", mem_if.mem_write_data, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 5; k++) run_vec(vecs[k]);

      // enable low in IDLE: a pending REQUEST must not start anything
      @(negedge clk);
      enable = 1'b0; core_state = CS_REQUEST; rd_en = 1'b1; rs = 8'h60;
      repeat (2) begin
         @(negedge clk);
         chk("frz_idle_state", lsu_state, 2'b00);
         chk("frz_idle_rvalid", mem_if.mem_read_valid, 1'b0);
      end
      core_state = CS_IDLE; rd_en = 1'b0;
      enable = 1'b1;

      // enable low in WAITING with ready high: frozen until enable returns
      @(negedge clk);
      core_state = CS_REQUEST; rd_en = 1'b1; rs = 8'h44;
      @(negedge clk);
      core_state = CS_WAIT; rd_en = 1'b0;
      @(negedge clk);
      enable = 1'b0; mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'h99;
      repeat (2) begin
         @(negedge clk);
         chk("frz_wait_state", lsu_state, 2'b10);
         chk("frz_wait_rvalid", mem_if.mem_read_valid, 1'b1);
         chk("frz_wait_out", lsu_out, 8'h00);
      end
      enable = 1'b1;
      @(negedge clk);
      mem_if.mem_read_ready = 1'b0;
      chk("unfrz_state", lsu_state, 2'b11);
      chk("unfrz_out", lsu_out, 8'h99);
      chk("unfrz_rvalid", mem_if.mem_read_valid, 1'b0);
      core_state = CS_UPDATE;
      @(negedge clk);
      chk("unfrz_idle", lsu_state, 2'b00);
      core_state = CS_IDLE;

      // async reset mid-WAITING: outputs clear before any clock edge
      @(negedge clk);
      core_state = CS_REQUEST; rd_en = 1'b1; rs = 8'h50;
      @(negedge clk);
      core_state = CS_WAIT; rd_en = 1'b0;
      @(negedge clk);
      chk("arst_pre_rvalid", mem_if.mem_read_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("arst_rvalid", mem_if.mem_read_valid, 1'b0);
      chk("arst_state", lsu_state, 2'b00);
      chk("arst_out", lsu_out, 8'h00);
      chk("arst_raddr", mem_if.mem_read_address, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("arst_after_state", lsu_state, 2'b00);
      chk("arst_after_rvalid", mem_if.mem_read_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
